// File: rtl/wb_stream_wr_pkg.sv
// Shared constants and FSM encoding for the stream-to-Wishbone RAM writer.
// Burst mode is selected by defining WB_STREAM_WR_BURST_EN.
package wb_stream_wr_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/wb_stream_wr_fifo.sv
// Small synchronous FIFO with full/empty flags and a synchronous flush.
// Push is dropped when full, pop is dropped when empty; flush wins over both.
module wb_stream_wr_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        do_push = push_i && !full_o && !flush_i;
        do_pop  = pop_i && !empty_o && !flush_i;
        rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_stream_ram_writer.sv
// Wishbone master that buffers a valid/ready word stream and writes it to consecutive RAM words.
// WB_STREAM_WR_BURST_EN selects incrementing bursts; otherwise classic single-beat cycles.
module wb_stream_ram_writer
    import wb_stream_wr_pkg::*;
#(
    parameter int unsigned Dw         = 32,
    parameter int unsigned Aw         = 10,
    parameter int unsigned SELw       = Dw / 8,
    parameter int unsigned CTIw       = 3,
    parameter int unsigned BTEw       = 2,
    parameter int unsigned LENw       = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [Aw-1:0]   base_addr_i,
    input  logic [LENw-1:0] max_len_i,
    input  logic [Dw-1:0]   s_dat_i,
    input  logic            s_last_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    output logic [Dw-1:0]   m_dat_o,
    output logic [SELw-1:0] m_sel_o,
    output logic [Aw-1:0]   m_addr_o,
    output logic [CTIw-1:0] m_cti_o,
    output logic [BTEw-1:0] m_bte_o,
    output logic            m_stb_o,
    output logic            m_cyc_o,
    output logic            m_we_o,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    input  logic            m_rty_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [LENw-1:0] word_cnt_o
);

    wr_state_e       state_q;
    logic [Aw-1:0]   addr_q;
    logic [LENw-1:0] max_len_q;
    logic [LENw-1:0] acc_cnt_q;
    logic [LENw-1:0] word_cnt_q;
    logic            last_acc_q;
    logic            hold_q;   // keeps cyc asserted between beats of one transfer
    logic            gap_q;    // classic mode: one idle cycle after every ack
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic            fifo_full;
    logic            fifo_empty;
    logic [Dw:0]     head;
    logic            push;
    logic            in_last;
    logic            beat_ack;
    logic            beat_err;
    logic            final_beat;

    wb_stream_wr_fifo #(
        .Width (Dw + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (beat_err),
        .push_i  (push),
        .wdata_i ({in_last, s_dat_i}),
        .pop_i   (beat_ack),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        s_ready_o  = (state_q == ST_WRITE) && !fifo_full && (acc_cnt_q < max_len_q) &&
                     !last_acc_q;
        push       = s_valid_i && s_ready_o;
        in_last    = s_last_i || (acc_cnt_q == max_len_q - LENw'(1));
        m_stb_o    = (state_q == ST_WRITE) && !fifo_empty && !gap_q;
        beat_err   = m_stb_o && m_err_i;
        beat_ack   = m_stb_o && m_ack_i && !m_err_i && !m_rty_i;
        final_beat = head[Dw];
        m_cyc_o    = m_stb_o || hold_q;
        m_we_o     = m_cyc_o;
        m_sel_o    = {SELw{m_cyc_o}};
        m_dat_o    = m_stb_o ? head[Dw-1:0] : '0;
        m_addr_o   = addr_q;
        m_bte_o    = BTEw'(BTE_LINEAR);
`ifdef WB_STREAM_WR_BURST_EN
        if (!m_stb_o)        m_cti_o = '0;
        else if (final_beat) m_cti_o = CTIw'(CTI_END);
        else                 m_cti_o = CTIw'(CTI_INC);
`else
        m_cti_o    = CTIw'(CTI_CLASSIC);
`endif
        busy_o     = busy_q;
        done_o     = done_q;
        err_o      = err_q;
        word_cnt_o = word_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            max_len_q  <= '0;
            acc_cnt_q  <= '0;
            word_cnt_q <= '0;
            last_acc_q <= 1'b0;
            hold_q     <= 1'b0;
            gap_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            gap_q  <= 1'b0;
            if (push) begin
                acc_cnt_q <= acc_cnt_q + LENw'(1);
                if (in_last) last_acc_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // A zero-length start only produces a one-cycle busy/done pulse.
                    busy_q <= start_i;
                    if (start_i) begin
                        addr_q     <= base_addr_i;
                        max_len_q  <= max_len_i;
                        acc_cnt_q  <= '0;
                        last_acc_q <= 1'b0;
                        word_cnt_q <= '0;
                        err_q      <= 1'b0;
                        hold_q     <= 1'b0;
                        if (max_len_i == '0) done_q  <= 1'b1;
                        else                 state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (beat_err) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                    end else if (beat_ack) begin
                        addr_q     <= addr_q + Aw'(1);
                        word_cnt_q <= word_cnt_q + LENw'(1);
                        if (final_beat) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            hold_q  <= 1'b0;
                        end else begin
`ifdef WB_STREAM_WR_BURST_EN
                            hold_q <= 1'b1;
`else
                            hold_q <= 1'b0;
                            gap_q  <= 1'b1;
`endif
                        end
                    end else if (m_stb_o) begin
                        hold_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
